// File: rtl/hsyncfifo_param.sv
// Parametrised single-clock FIFO with FWFT or registered read, occupancy count and almost-empty/full thresholds.
// Optional sticky overflow/underflow flags are built only when HSYNCFIFO_ERR_EN is defined.
module hsyncfifo_param #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int AHEAD = 1,
  parameter int AE    = 2,
  parameter int AF    = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DW-1:0]             di,
  input  logic                      we,
  input  logic                      re,
  output logic [DW-1:0]             dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty_flag,
  output logic                      full_flag,
  output logic                      aempty_flag,
  output logic                      afull_flag
`ifdef HSYNCFIFO_ERR_EN
  ,
  input  logic                      err_clr,
  output logic                      ovf_flag,
  output logic                      udf_flag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AE    = (AW+1)'(AE);
  localparam logic [AW:0] LP_AF    = (AW+1)'(AF);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_aempty;
  logic          r_afull;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_cnt_nxt;

  // Acceptance uses the registered flags, so a full FIFO drops writes even when a read frees a slot.
  assign w_wr_ok = we & ~r_full;
  assign w_rd_ok = re & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_cnt_nxt;
      r_empty  <= (w_cnt_nxt == '0);
      r_full   <= (w_cnt_nxt == LP_DEPTH);
      r_aempty <= (w_cnt_nxt <= LP_AE);
      r_afull  <= (w_cnt_nxt >= LP_AF);
    end
  end

  // Storage carries no reset; a reset only discards contents logically through the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= di;
  end

  generate
    if (AHEAD != 0) begin : g_fwft
      assign dout = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DW-1:0] r_dout;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_dout <= '0;
        else if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
      end
      assign dout = r_dout;
    end
  endgenerate

  assign count       = r_count;
  assign empty_flag  = r_empty;
  assign full_flag   = r_full;
  assign aempty_flag = r_aempty;
  assign afull_flag  = r_afull;

`ifdef HSYNCFIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // A set event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (we & r_full)        r_ovf <= 1'b1;
      else if (err_clr)       r_ovf <= 1'b0;
      if (re & r_empty)       r_udf <= 1'b1;
      else if (err_clr)       r_udf <= 1'b0;
    end
  end

  assign ovf_flag = r_ovf;
  assign udf_flag = r_udf;
`endif

endmodule
